// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared sizes, coefficient-bank type and FSM states for the
//            5-tap FIR sequencing controller.
// Revision : 1.0  initial release
// ============================================================================
package fir_pkg;
    localparam int WIDTH = 8;
    localparam int TAPS  = 5;
    localparam int CW    = 16;
    localparam int IDXW  = $clog2(TAPS);

    typedef logic [TAPS-1:0][WIDTH-1:0] coef_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;
endpackage
`default_nettype wire

// File: rtl/fir_seq_ctrl_coef_bank.sv
`default_nettype none
// ============================================================================
// Module   : coef_bank
// Brief    : TAPS coefficient registers written one word at a time by index.
// Revision : 1.0  initial release
// ============================================================================
module coef_bank
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDXW-1:0]  widx,
    input  logic [WIDTH-1:0] wdata,
    output coef_t            coef
);

    coef_t r_coef;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_coef <= '0;
        end else if (we) begin
            r_coef[widx] <= wdata;
        end
    end

    assign coef = r_coef;

endmodule
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_seq_ctrl
// Brief    : Loads coefficients, clears the FIR history, then streams samples
//            through the external datapath with valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
module fir_seq_ctrl
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    n_samples,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             dp_shift,
    output logic [WIDTH-1:0] dp_x,
    output coef_t            dp_coef,
    input  logic [WIDTH-1:0] dp_y,
    output logic             busy,
    output logic             done
);

    localparam logic [IDXW-1:0] c_idx_last = IDXW'(TAPS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_nsamp;
    logic [CW-1:0]    r_out_cnt;
    logic [IDXW-1:0]  r_idx;
    logic             r_pend;
    logic             r_mvalid;
    logic [WIDTH-1:0] r_mdata;
    logic             w_cfg_hs;
    logic             w_s_ready;
    logic             w_s_hs;
    logic             w_m_hs;
    logic             w_idx_last;

    assign w_cfg_hs   = (r_state == S_LOAD) && cfg_valid;
    assign w_s_ready  = (r_state == S_RUN) && !r_pend && !r_mvalid;
    assign w_s_hs     = w_s_ready && s_valid;
    assign w_m_hs     = r_mvalid && m_ready;
    assign w_idx_last = (r_idx == c_idx_last);

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        dp_shift    = 1'b0;
        dp_x        = '0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && w_idx_last) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                dp_shift = 1'b1;
                if (w_idx_last) w_state_nxt = (r_nsamp == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (w_s_hs) begin
                    dp_shift = 1'b1;
                    dp_x     = s_data;
                end
                // out_cnt already counts the result currently on m_data
                if (w_m_hs && (r_out_cnt == r_nsamp)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_nsamp   <= '0;
            r_out_cnt <= '0;
            r_idx     <= '0;
            r_pend    <= 1'b0;
            r_mvalid  <= 1'b0;
            r_mdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_s_hs;

            if ((r_state == S_IDLE) && start) begin
                r_nsamp   <= n_samples;
                r_out_cnt <= '0;
                r_idx     <= '0;
            end else if (w_cfg_hs || (r_state == S_CLEAR)) begin
                // One index serves as write pointer in LOAD and shift count in CLEAR
                r_idx <= w_idx_last ? '0 : r_idx + IDXW'(1);
            end

            if (r_pend) begin
                r_mdata   <= dp_y;
                r_mvalid  <= 1'b1;
                r_out_cnt <= r_out_cnt + CW'(1);
            end else if (w_m_hs) begin
                r_mvalid <= 1'b0;
            end
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_mvalid;
    assign m_data  = r_mdata;

    coef_bank u_coef_bank (
        .clk   (clk),
        .reset (reset),
        .we    (w_cfg_hs),
        .widx  (r_idx),
        .wdata (cfg_data),
        .coef  (dp_coef)
    );

endmodule
`default_nettype wire
